// File: rtl/mmio_pkg.sv
// Shared decode constants for the MMIO console target: register offsets,
// access-size encoding, STATUS/CTRL bit positions and the internal register select.
package mmio_pkg;

    localparam logic [7:0] OFF_TXDATA      = 8'h00;
    localparam logic [7:0] OFF_STATUS      = 8'h04;
    localparam logic [7:0] OFF_CTRL        = 8'h08;
    localparam logic [7:0] OFF_MTIME_LO    = 8'h0C;
    localparam logic [7:0] OFF_MTIME_HI    = 8'h10;
    localparam logic [7:0] OFF_MTIMECMP_LO = 8'h14;
    localparam logic [7:0] OFF_MTIMECMP_HI = 8'h18;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    localparam int ST_COUNT_W  = 7;
    localparam int ST_EMPTY    = 8;
    localparam int ST_FULL     = 9;
    localparam int ST_OVF      = 10;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [2:0] {
        R_TXDATA,
        R_STATUS,
        R_CTRL,
        R_MTIME_LO,
        R_MTIME_HI,
        R_MTIMECMP_LO,
        R_MTIMECMP_HI,
        R_NONE
    } reg_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO for the console TX path; power-of-two depth so the
// pointers wrap on natural overflow. A push into a full FIFO is taken only alongside a pop.
module sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // storage is data only; occupancy is tracked by the reset pointers/count
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mmio_console_target.sv
// MMIO console target: TX byte FIFO with drain handshake plus STATUS/CTRL registers.
// Define MMIO_TIMER_EN to add the 64-bit MTIME/MTIMECMP timer and its interrupt.
module mmio_console_target
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sel,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [1:0]        dlen,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              ack,
    output logic              err,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              both;
    logic              acc;
    logic              bad;
    logic              wr_ok;
    logic              rd_ok;
    logic [ADDR_W-1:0] base;
    reg_e              rsel;
    logic [31:0]       rdata_p0;

    logic              ack_p1;
    logic              err_p1;
    logic [31:0]       dout_p1;

    logic              tx_en;
    logic              irq_en;
    logic              ovf;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign both  = sel & re & we;
    assign acc   = sel & (re ^ we);
    assign base  = {daddr[ADDR_W-1:2], 2'b00};

    always_comb begin
        rsel = R_NONE;
        case (base)
            ADDR_W'(OFF_TXDATA):      rsel = R_TXDATA;
            ADDR_W'(OFF_STATUS):      rsel = R_STATUS;
            ADDR_W'(OFF_CTRL):        rsel = R_CTRL;
`ifdef MMIO_TIMER_EN
            ADDR_W'(OFF_MTIME_LO):    rsel = R_MTIME_LO;
            ADDR_W'(OFF_MTIME_HI):    rsel = R_MTIME_HI;
            ADDR_W'(OFF_MTIMECMP_LO): rsel = R_MTIMECMP_LO;
            ADDR_W'(OFF_MTIMECMP_HI): rsel = R_MTIMECMP_HI;
`endif
            default:                  rsel = R_NONE;
        endcase
    end

    // TXDATA takes any size; every other register is word-only
    assign bad   = (dlen == SZ_RSVD) | (rsel == R_NONE)
                 | ((rsel != R_TXDATA) & (dlen != SZ_WORD))
                 | ((dlen == SZ_WORD) & (daddr[1:0] != 2'b00));
    assign wr_ok = acc & ~bad & we;
    assign rd_ok = acc & ~bad & re;

    assign push     = wr_ok & (rsel == R_TXDATA);
    assign tx_valid = tx_en & ~fifo_empty;
    assign pop      = tx_valid & tx_ready;

    sync_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (din[7:0]),
        .rdata (tx_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (wr_ok && rsel == R_CTRL) tx_en <= din[CTRL_TX_EN];
            if (push && fifo_full && !pop) ovf <= 1'b1;
            else if (wr_ok && rsel == R_STATUS && din[ST_OVF]) ovf <= 1'b0;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [63:0] mtime_nx;
    logic        irq_q;

    // a half-write overrides only its own half of this cycle's increment
    always_comb begin
        mtime_nx = mtime + 64'd1;
        if (wr_ok && rsel == R_MTIME_LO) mtime_nx[31:0]  = din;
        if (wr_ok && rsel == R_MTIME_HI) mtime_nx[63:32] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en   <= 1'b0;
            mtime    <= '0;
            mtimecmp <= '1;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ok && rsel == R_CTRL)        irq_en          <= din[CTRL_IRQ_EN];
            if (wr_ok && rsel == R_MTIMECMP_LO) mtimecmp[31:0]  <= din;
            if (wr_ok && rsel == R_MTIMECMP_HI) mtimecmp[63:32] <= din;
            mtime <= mtime_nx;
            irq_q <= irq_en & (mtime >= mtimecmp);
        end
    end

    assign irq = irq_q;
`else
    logic unused_bits;

    assign irq_en      = 1'b0;
    assign irq         = 1'b0;
    assign unused_bits = ^{din[31:11], din[9:8]};
`endif

    always_comb begin
        rdata_p0 = '0;
        if (rd_ok) begin
            case (rsel)
                R_STATUS: begin
                    rdata_p0[ST_COUNT_W-1:0] = ST_COUNT_W'(fifo_count);
                    rdata_p0[ST_EMPTY]       = fifo_empty;
                    rdata_p0[ST_FULL]        = fifo_full;
                    rdata_p0[ST_OVF]         = ovf;
                end
                R_CTRL: begin
                    rdata_p0[CTRL_TX_EN]  = tx_en;
                    rdata_p0[CTRL_IRQ_EN] = irq_en;
                end
`ifdef MMIO_TIMER_EN
                R_MTIME_LO:    rdata_p0 = mtime[31:0];
                R_MTIME_HI:    rdata_p0 = mtime[63:32];
                R_MTIMECMP_LO: rdata_p0 = mtimecmp[31:0];
                R_MTIMECMP_HI: rdata_p0 = mtimecmp[63:32];
`endif
                default:       rdata_p0 = '0;
            endcase
        end
    end

    // ---- p0 -> p1: response stage; only the strobe is reset, payload is gated by it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_p1 <= 1'b0;
        else        ack_p1 <= acc | both;
    end

    always_ff @(posedge clk) begin
        err_p1  <= both | (acc & bad);
        dout_p1 <= rdata_p0;
    end

    assign ack  = ack_p1;
    assign err  = ack_p1 & err_p1;
    assign dout = ack_p1 ? dout_p1 : 32'd0;

endmodule
